// File: rtl/controle_de_busca_if.sv
// Fetch-side bus of controle_de_busca: instruction memory port, instruction
// register hand-off to decode, redirect input from execute and status flags.
// Optional FETCH_PERF_CNT_EN adds the ciclos/instrucoes counter outputs.
//
// Hand-off protocol (ir_valid/ir_ready): ir_out/ir_pc are meaningful only
// while ir_valid=1; a word is consumed on a rising edge where ir_valid=1 and
// ir_ready=1; while ir_valid=1 and ir_ready=0 the producer holds ir_out/ir_pc
// unchanged; ir_ready may be asserted at any time, independent of ir_valid.
interface controle_de_busca_if;
    logic        start;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halted;
    logic        addr_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ciclos;
    logic [31:0] instrucoes;
`endif

    // Fetch controller side.
    modport master (
        input  start, instrucao, ir_ready, redirect_valid, redirect_addr,
        output endereco, ir_out, ir_pc, ir_valid, halted, addr_fault
`ifdef FETCH_PERF_CNT_EN
        , output ciclos, instrucoes
`endif
    );

    // Environment side: memory, decode and execute.
    modport slave (
        output start, instrucao, ir_ready, redirect_valid, redirect_addr,
        input  endereco, ir_out, ir_pc, ir_valid, halted, addr_fault
`ifdef FETCH_PERF_CNT_EN
        , input ciclos, instrucoes
`endif
    );
endinterface

// File: rtl/controle_de_busca.sv
// controle_de_busca: instruction-fetch sequencer for memoriaDeInstrucoes.
// Owns the PC, presents it as the memory address, registers each returned
// word into the instruction register and hands it to decode via ir_valid /
// ir_ready. Stops on hlt, follows execute redirects, faults on fetches past
// the end of memory. Optional macro FETCH_PERF_CNT_EN adds saturating
// cycle/instruction counters (ciclos, instrucoes) on the interface.
module controle_de_busca #(
    parameter logic [31:0] START_ADDR = 32'd1,
    parameter logic [31:0] MEM_DEPTH  = 32'd21,
    parameter logic [4:0]  HLT_OPCODE = 5'd18
) (
    input  logic                       clock,
    input  logic                       reset,
    controle_de_busca_if.master        bus,
    output logic [1:0]                 estado_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } estado_t;

    estado_t     state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_out_q;
    logic [31:0] ir_pc_q;
    logic        ir_valid_q;
    logic        halted_q;
    logic        addr_fault_q;

    logic        capture_en;
    logic        pc_fora;
    logic        is_hlt;

    // The IR slot is free when empty or being drained by decode this cycle.
    assign capture_en = !ir_valid_q || bus.ir_ready;
    assign pc_fora    = (pc_q >= MEM_DEPTH);
    assign is_hlt     = (bus.instrucao[31:27] == HLT_OPCODE);

    // Memory is read combinationally at the current PC.
    assign bus.endereco   = pc_q;
    assign bus.ir_out     = ir_out_q;
    assign bus.ir_pc      = ir_pc_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.halted     = halted_q;
    assign bus.addr_fault = addr_fault_q;
    assign estado_o       = state_q;

    // Fetch FSM: redirect beats start beats capture/consume.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= START_ADDR;
            ir_out_q     <= 32'd0;
            ir_pc_q      <= 32'd0;
            ir_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= FETCH;
                        pc_q    <= START_ADDR;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        // Flush whatever sits in the IR, even if consumed now.
                        ir_valid_q <= 1'b0;
                        pc_q       <= bus.redirect_addr;
                    end else if (capture_en) begin
                        if (pc_fora) begin
                            ir_valid_q   <= 1'b0;
                            addr_fault_q <= 1'b1;
                            state_q      <= DRAIN;
                        end else begin
                            ir_out_q   <= bus.instrucao;
                            ir_pc_q    <= pc_q;
                            ir_valid_q <= 1'b1;
                            if (is_hlt) begin
                                // PC stays on the hlt word.
                                state_q <= DRAIN;
                            end else begin
                                pc_q <= pc_q + 32'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) begin
                        ir_valid_q <= 1'b0;
                        pc_q       <= bus.redirect_addr;
                        state_q    <= FETCH;
                    end else if (!ir_valid_q || bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                        state_q    <= HALTED;
                    end
                end
                HALTED: begin
                    if (bus.start) begin
                        state_q      <= FETCH;
                        pc_q         <= START_ADDR;
                        halted_q     <= 1'b0;
                        addr_fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ciclos_q;
    logic [31:0] instrucoes_q;
    logic        start_aceito;
    logic        consumido;
    logic        ativo;

    assign start_aceito = bus.start && ((state_q == IDLE) || (state_q == HALTED));
    assign consumido    = ir_valid_q && bus.ir_ready && !bus.redirect_valid;
    assign ativo        = (state_q == FETCH) || (state_q == DRAIN);

    assign bus.ciclos     = ciclos_q;
    assign bus.instrucoes = instrucoes_q;

    // Saturating activity counters, cleared when a run is (re)started.
    always_ff @(posedge clock) begin
        if (reset || start_aceito) begin
            ciclos_q     <= 32'd0;
            instrucoes_q <= 32'd0;
        end else begin
            if (ativo && (ciclos_q != 32'hFFFF_FFFF)) begin
                ciclos_q <= ciclos_q + 32'd1;
            end
            if (consumido && (instrucoes_q != 32'hFFFF_FFFF)) begin
                instrucoes_q <= instrucoes_q + 32'd1;
            end
        end
    end
`endif

endmodule
